// File: rtl/snake_pkg.sv
// Shared constants, segment record and reader FSM states for the snake segment store.
package snake_pkg;

  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int MAX_LEN = 64;

  localparam int ROW_W  = $clog2(GRID_H);
  localparam int COL_W  = $clog2(GRID_W);
  localparam int ADDR_W = $clog2(MAX_LEN);

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } seg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } rd_state_t;

  // Requested lengths beyond the ring depth are truncated to the full ring.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    if (len > (ADDR_W+1)'(MAX_LEN)) return (ADDR_W+1)'(MAX_LEN);
    return len;
  endfunction

endpackage

// File: rtl/snake_row_reader_flopenrn.sv
// Enabled flop with asynchronous active-low reset; holds row_mask/collide between scans.
module flopenrn #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/snake_row_reader.sv
// Walks the segment ring from head toward tail and builds the occupancy mask of one tile row.
// Optional self-collision detection is enabled by defining SNAKE_COLLIDE_EN.
module snake_row_reader
  import snake_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ROW_W-1:0]       row,
  input  logic [ADDR_W-1:0]      head_ptr,
  input  logic [ADDR_W:0]        length,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [ROW_W+COL_W-1:0] rd_data,
  output logic                   busy,
  output logic                   done,
  output logic [GRID_W-1:0]      row_mask,
  output logic                   collide
);

  rd_state_t          state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  head_q, head_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [GRID_W-1:0]  work_q, work_d;
  logic               rd_vld_q, rd_vld_d;
  logic [ADDR_W:0]    start_len;
  seg_t               seg;
  logic               col_ok;
  logic               hit;

`ifdef SNAKE_COLLIDE_EN
  logic               coll_q, coll_d;
`endif

  assign seg       = seg_t'(rd_data);
  assign start_len = clamp_len(length);

  // A full-width column field can never address past the grid, so no compare is needed.
  generate
    if (GRID_W >= (1 << COL_W)) begin : g_col_full
      assign col_ok = 1'b1;
    end else begin : g_col_part
      assign col_ok = ({1'b0, seg.col} < (COL_W+1)'(GRID_W));
    end
  endgenerate

  assign hit = rd_vld_q && (seg.row == row_q) && col_ok;

  // Ring walks backward from head; underflow wraps by adding the ring depth.
  always_comb begin
    if ({1'b0, head_q} >= cnt_q) rd_addr = ADDR_W'({1'b0, head_q} - cnt_q);
    else rd_addr = ADDR_W'({1'b0, head_q} + (ADDR_W+1)'(MAX_LEN) - cnt_q);
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    head_d   = head_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    rd_vld_d = (state_q == ST_READ);
`ifdef SNAKE_COLLIDE_EN
    coll_d   = coll_q;
    if (hit && work_q[seg.col]) coll_d = 1'b1;
`endif
    if (hit) work_d[seg.col] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d   = row;
          head_d  = head_ptr;
          len_d   = start_len;
          cnt_d   = '0;
          work_d  = '0;
`ifdef SNAKE_COLLIDE_EN
          coll_d  = 1'b0;
`endif
          state_d = (start_len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        if (cnt_q == len_q - (ADDR_W+1)'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      head_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      work_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      head_q   <= head_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign rd_en = (state_q == ST_READ);
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

  flopenrn #(.WIDTH(GRID_W)) u_mask_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (done),
    .d       (work_q),
    .q       (row_mask)
  );

`ifdef SNAKE_COLLIDE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) coll_q <= 1'b0;
    else          coll_q <= coll_d;
  end

  flopenrn #(.WIDTH(1)) u_coll_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (done),
    .d       (coll_q),
    .q       (collide)
  );
`else
  assign collide = 1'b0;
`endif

endmodule
